// File: rtl/fwd_scoreboard_if.sv
// rtl/fwd_scoreboard_if.sv - EX/ID operand bundle and forwarding results for the scoreboard
interface fwd_scoreboard_if #(
    parameter int REG_AW = 5,
    parameter int DEPTH  = 2,
    parameter int NSRC   = 2,
    parameter int CNT_W  = 16
);
    localparam int SEL_W = $clog2(DEPTH + 1);

    logic                    en;
    logic                    ex_valid;
    logic                    ex_regwrite;
    logic                    ex_is_load;
    logic [REG_AW-1:0]       ex_rd;
    logic [NSRC*REG_AW-1:0]  ex_rs;
    logic [NSRC*REG_AW-1:0]  id_rs;
    logic [NSRC-1:0]         id_rs_used;
    logic [NSRC*SEL_W-1:0]   fwd_sel;
    logic                    stall_id;
    logic [CNT_W-1:0]        stall_cnt;
    logic                    fwd_err;

    modport master (
        output en, ex_valid, ex_regwrite, ex_is_load, ex_rd, ex_rs, id_rs, id_rs_used,
        input  fwd_sel, stall_id, stall_cnt, fwd_err
    );

    modport slave (
        input  en, ex_valid, ex_regwrite, ex_is_load, ex_rd, ex_rs, id_rs, id_rs_used,
        output fwd_sel, stall_id, stall_cnt, fwd_err
    );
endinterface

// File: rtl/fwd_scoreboard.sv
// rtl/fwd_scoreboard.sv - EX-stage bypass select and load-use stall unit
module fwd_scoreboard #(
    parameter int REG_AW   = 5,
    parameter int DEPTH    = 2,
    parameter int NSRC     = 2,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    fwd_scoreboard_if.slave   bus
);
    localparam int SEL_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]              hist_v;
    logic [DEPTH-1:0]              hist_ld;
    logic [DEPTH-1:0][REG_AW-1:0]  hist_rd;

    logic [NSRC-1:0][SEL_W-1:0]    sel;
    logic [NSRC-1:0]               unsafe;
    logic [NSRC-1:0]               prod_early;
    logic [NSRC-1:0]               need_stall;
    logic                          stall;

    // Scan oldest to youngest so the youngest matching entry is the last to write.
    always_comb begin
        sel    = '0;
        unsafe = '0;
        for (int i = 0; i < NSRC; i++) begin
            for (int j = DEPTH - 1; j >= 0; j--) begin
                if (rst_n && bus.ex_rs[i*REG_AW +: REG_AW] != '0 && hist_v[j] &&
                    hist_rd[j] == bus.ex_rs[i*REG_AW +: REG_AW]) begin
                    sel[i]    = SEL_W'(j + 1);
                    unsafe[i] = hist_ld[j] && (j < LOAD_LAT);
                end
            end
        end
    end

    // Position p is where the producer sits once the ID instruction reaches EX.
    always_comb begin
        prod_early = '0;
        need_stall = '0;
        for (int i = 0; i < NSRC; i++) begin
            for (int j = DEPTH - 1; j >= 0; j--) begin
                if (hist_v[j] && hist_rd[j] == bus.id_rs[i*REG_AW +: REG_AW]) begin
                    prod_early[i] = hist_ld[j] && (j + 1 < LOAD_LAT);
                end
            end
            if (bus.ex_valid && bus.ex_regwrite && bus.ex_rd == bus.id_rs[i*REG_AW +: REG_AW]) begin
                prod_early[i] = bus.ex_is_load && (LOAD_LAT > 0);
            end
            need_stall[i] = rst_n && bus.id_rs_used[i] &&
                            (bus.id_rs[i*REG_AW +: REG_AW] != '0) && prod_early[i];
        end
    end

    assign stall        = |need_stall;
    assign bus.stall_id = stall;
    assign bus.fwd_sel  = sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_v  <= '0;
            hist_ld <= '0;
            hist_rd <= '0;
        end else if (bus.en) begin
            for (int j = DEPTH - 1; j > 0; j--) begin
                hist_v[j]  <= hist_v[j-1];
                hist_ld[j] <= hist_ld[j-1];
                hist_rd[j] <= hist_rd[j-1];
            end
            hist_v[0]  <= bus.ex_valid && bus.ex_regwrite && (bus.ex_rd != '0);
            hist_ld[0] <= bus.ex_is_load;
            hist_rd[0] <= bus.ex_rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.stall_cnt <= '0;
            bus.fwd_err   <= 1'b0;
        end else if (bus.en) begin
            if (stall && bus.stall_cnt != '1) begin
                bus.stall_cnt <= bus.stall_cnt + 1'b1;
            end
            if (|unsafe) begin
                bus.fwd_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb/tb_fwd_scoreboard.sv - directed and random checks of fwd_scoreboard against a queue model
module tb_fwd_scoreboard;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fwd_scoreboard_if #(.REG_AW(5), .DEPTH(2), .NSRC(2), .CNT_W(16)) i1 ();
    fwd_scoreboard_if #(.REG_AW(5), .DEPTH(3), .NSRC(2), .CNT_W(16)) i2 ();

    fwd_scoreboard #(.REG_AW(5), .DEPTH(2), .NSRC(2), .LOAD_LAT(1), .CNT_W(16))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(i1));
    fwd_scoreboard #(.REG_AW(5), .DEPTH(3), .NSRC(2), .LOAD_LAT(2), .CNT_W(16))
        dut2 (.clk(clk), .rst_n(rst_n), .bus(i2));

    logic       b_en    [2];
    logic       b_valid [2];
    logic       b_rw    [2];
    logic       b_ld    [2];
    logic [4:0] b_rd    [2];
    logic [4:0] b_ex_rs [2][2];
    logic [4:0] b_id_rs [2][2];
    logic [1:0] b_used  [2];

    assign i1.en = b_en[0];             assign i2.en = b_en[1];
    assign i1.ex_valid = b_valid[0];    assign i2.ex_valid = b_valid[1];
    assign i1.ex_regwrite = b_rw[0];    assign i2.ex_regwrite = b_rw[1];
    assign i1.ex_is_load = b_ld[0];     assign i2.ex_is_load = b_ld[1];
    assign i1.ex_rd = b_rd[0];          assign i2.ex_rd = b_rd[1];
    assign i1.ex_rs = {b_ex_rs[0][1], b_ex_rs[0][0]};
    assign i2.ex_rs = {b_ex_rs[1][1], b_ex_rs[1][0]};
    assign i1.id_rs = {b_id_rs[0][1], b_id_rs[0][0]};
    assign i2.id_rs = {b_id_rs[1][1], b_id_rs[1][0]};
    assign i1.id_rs_used = b_used[0];   assign i2.id_rs_used = b_used[1];

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       ld;
    } wr_t;

    // Model: list of past EX writes, newest first; only the first DEPTH are visible.
    wr_t         past [2][$];
    logic [15:0] e_cnt [2];
    logic        e_err [2];
    int checks = 0;
    int errors = 0;

    function automatic int depth_of(int d);
        return (d == 0) ? 2 : 3;
    endfunction

    function automatic int lat_of(int d);
        return (d == 0) ? 1 : 2;
    endfunction

    function automatic int m_sel(int d, logic [4:0] rs);
        if (!rst_n || rs == 5'd0) return 0;
        for (int j = 0; j < depth_of(d) && j < past[d].size(); j++)
            if (past[d][j].v && past[d][j].rd == rs) return j + 1;
        return 0;
    endfunction

    function automatic bit m_stall(int d);
        int p;
        bit is_ld;
        logic [4:0] rs;
        if (!rst_n) return 1'b0;
        for (int i = 0; i < 2; i++) begin
            rs = b_id_rs[d][i];
            p = -1;
            is_ld = 1'b0;
            if (!b_used[d][i] || rs == 5'd0) continue;
            if (b_valid[d] && b_rw[d] && b_rd[d] == rs) begin
                p = 0;
                is_ld = b_ld[d];
            end else begin
                for (int j = 0; j < depth_of(d) && j < past[d].size(); j++) begin
                    if (past[d][j].v && past[d][j].rd == rs) begin
                        p = j + 1;
                        is_ld = past[d][j].ld;
                        break;
                    end
                end
            end
            if (p >= 0 && is_ld && p < lat_of(d)) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit m_unsafe(int d);
        int s;
        for (int i = 0; i < 2; i++) begin
            s = m_sel(d, b_ex_rs[d][i]);
            if (s > 0 && past[d][s-1].ld && (s - 1) < lat_of(d)) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_advance(int d);
        wr_t w;
        if (!rst_n || !b_en[d]) return;
        if (m_unsafe(d)) e_err[d] = 1'b1;
        if (m_stall(d) && e_cnt[d] != 16'hffff) e_cnt[d] = e_cnt[d] + 16'd1;
        w.v  = b_valid[d] && b_rw[d] && (b_rd[d] != 5'd0);
        w.rd = b_rd[d];
        w.ld = b_ld[d];
        past[d].push_front(w);
        if (past[d].size() > 4) void'(past[d].pop_back());
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            past[d].delete();
            e_cnt[d] = 16'd0;
            e_err[d] = 1'b0;
        end
    endtask

    function automatic logic [31:0] o_sel(int d, int i);
        if (d == 0) return 32'(i1.fwd_sel[i*2 +: 2]);
        return 32'(i2.fwd_sel[i*2 +: 2]);
    endfunction
    function automatic logic [31:0] o_stall(int d);
        return (d == 0) ? 32'(i1.stall_id) : 32'(i2.stall_id);
    endfunction
    function automatic logic [31:0] o_cnt(int d);
        return (d == 0) ? 32'(i1.stall_cnt) : 32'(i2.stall_cnt);
    endfunction
    function automatic logic [31:0] o_err(int d);
        return (d == 0) ? 32'(i1.fwd_err) : 32'(i2.fwd_err);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s d%0d sel0", tag, d), o_sel(d, 0), 32'(m_sel(d, b_ex_rs[d][0])));
            chk($sformatf("%s d%0d sel1", tag, d), o_sel(d, 1), 32'(m_sel(d, b_ex_rs[d][1])));
            chk($sformatf("%s d%0d stall", tag, d), o_stall(d), 32'(m_stall(d)));
            chk($sformatf("%s d%0d cnt", tag, d), o_cnt(d), 32'(e_cnt[d]));
            chk($sformatf("%s d%0d err", tag, d), o_err(d), 32'(e_err[d]));
        end
    endtask

    task automatic tick();
        for (int d = 0; d < 2; d++) model_advance(d);
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(int d, logic v, logic rw, logic ld, logic [4:0] rd,
                          logic [4:0] r0, logic [4:0] r1);
        b_valid[d] = v; b_rw[d] = rw; b_ld[d] = ld; b_rd[d] = rd;
        b_ex_rs[d][0] = r0; b_ex_rs[d][1] = r1;
    endtask

    task automatic set_id(int d, logic [4:0] r0, logic [4:0] r1, logic [1:0] used);
        b_id_rs[d][0] = r0; b_id_rs[d][1] = r1; b_used[d] = used;
    endtask

    task automatic idle(int d);
        set_ex(d, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        set_id(d, 5'd0, 5'd0, 2'b00);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            b_en[d] = 1'b1;
            idle(d);
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;

        // back-to-back ALU dependency
        set_ex(0, 1, 1, 0, 5'd5, 5'd0, 5'd0);
        check_all("b2b_prod");
        tick();
        set_ex(0, 1, 1, 0, 5'd9, 5'd5, 5'd0);
        check_all("b2b_cons");
        chk("b2b_sel0_const", o_sel(0, 0), 32'd1);
        tick();

        // youngest of two producers wins, then rd=0 producers never forward
        set_ex(0, 1, 1, 0, 5'd7, 5'd0, 5'd0); tick();
        set_ex(0, 1, 1, 0, 5'd7, 5'd0, 5'd0); tick();
        set_ex(0, 1, 1, 0, 5'd1, 5'd0, 5'd7);
        check_all("prio");
        chk("prio_sel1_const", o_sel(0, 1), 32'd1);
        tick();
        set_ex(0, 1, 1, 0, 5'd0, 5'd0, 5'd0); tick();
        set_ex(0, 1, 1, 0, 5'd0, 5'd0, 5'd0); tick();
        set_ex(0, 1, 1, 0, 5'd2, 5'd0, 5'd0);
        check_all("rd0");
        chk("rd0_sel_const", o_sel(0, 0) | o_sel(0, 1), 32'd0);
        tick();

        // load-use, LOAD_LAT=1
        set_ex(0, 1, 1, 1, 5'd3, 5'd0, 5'd0);
        set_id(0, 5'd3, 5'd0, 2'b01);
        check_all("lu_ld");
        chk("lu_stall_const", o_stall(0), 32'd1);
        tick();
        set_ex(0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        check_all("lu_bubble");
        chk("lu_cnt_const", o_cnt(0), 32'd1);
        chk("lu_nostall_const", o_stall(0), 32'd0);
        tick();
        set_ex(0, 1, 1, 0, 5'd8, 5'd3, 5'd0);
        set_id(0, 5'd0, 5'd0, 2'b00);
        check_all("lu_cons");
        chk("lu_sel_const", o_sel(0, 0), 32'd2);
        tick();
        chk("lu_err_const", o_err(0), 32'd0);

        // load-use, DEPTH=3 LOAD_LAT=2
        set_ex(1, 1, 1, 1, 5'd3, 5'd0, 5'd0);
        set_id(1, 5'd3, 5'd0, 2'b01);
        check_all("lu2_ld");
        tick();
        set_ex(1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        check_all("lu2_b1");
        chk("lu2_stall_b1_const", o_stall(1), 32'd1);
        tick();
        check_all("lu2_b2");
        chk("lu2_stall_b2_const", o_stall(1), 32'd0);
        chk("lu2_cnt_const", o_cnt(1), 32'd2);
        tick();
        set_ex(1, 1, 1, 0, 5'd9, 5'd3, 5'd0);
        set_id(1, 5'd0, 5'd0, 2'b00);
        check_all("lu2_cons");
        chk("lu2_sel_const", o_sel(1, 0), 32'd3);
        tick();
        set_ex(1, 1, 1, 1, 5'd6, 5'd0, 5'd0); tick();
        set_ex(1, 1, 1, 0, 5'd10, 5'd6, 5'd0);
        check_all("early");
        tick();
        idle(1);
        check_all("early_after");
        chk("early_err_const", o_err(1), 32'd1);
        tick(); tick();
        chk("early_sticky_const", o_err(1), 32'd1);

        // younger non-load producer masks the load
        set_ex(0, 1, 1, 1, 5'd4, 5'd0, 5'd0); tick();
        set_ex(0, 1, 1, 0, 5'd4, 5'd0, 5'd0);
        set_id(0, 5'd4, 5'd0, 2'b01);
        check_all("mask");
        chk("mask_nostall_const", o_stall(0), 32'd0);
        tick();
        set_ex(0, 1, 1, 1, 5'd2, 5'd4, 5'd0);
        set_id(0, 5'd2, 5'd0, 2'b01);
        check_all("mask_cons");
        chk("mask_sel_const", o_sel(0, 0), 32'd1);

        // freeze while stalled
        b_en[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_all($sformatf("freeze%0d", k));
            chk("freeze_sel_const", o_sel(0, 0), 32'd1);
            chk("freeze_stall_const", o_stall(0), 32'd1);
            chk("freeze_cnt_const", o_cnt(0), 32'd1);
        end
        b_en[0] = 1'b1;
        tick();
        check_all("thaw");

        // asynchronous reset while stalled
        set_ex(0, 1, 1, 1, 5'd3, 5'd0, 5'd0);
        set_id(0, 5'd3, 5'd0, 2'b01);
        check_all("pre_rst");
        #3;
        rst_n = 1'b0;
        model_reset();
        check_all("mid_rst");
        chk("mid_rst_stall_const", o_stall(0), 32'd0);
        chk("mid_rst_cnt_const", o_cnt(0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            idle(d);
            b_ex_rs[d][0] = 5'd3;
            b_ex_rs[d][1] = 5'd6;
        end
        for (int k = 0; k < 3; k++) begin
            check_all($sformatf("post_rst%0d", k));
            chk("post_rst_sel_const", o_sel(0, 0) | o_sel(1, 0), 32'd0);
            tick();
        end

        // random traffic
        for (int n = 0; n < 400; n++) begin
            for (int d = 0; d < 2; d++) begin
                b_en[d] = ($urandom_range(0, 4) != 0);
                set_ex(d, 1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom_range(0, 7)),
                       5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
                set_id(d, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 2'($urandom));
            end
            check_all($sformatf("rnd%0d", n));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fwd_scoreboard.md
# fwd_scoreboard

Parametrised forwarding and load-use hazard unit for the execute stage. It keeps a registered shift history of in-flight register writes for `DEPTH` stages past EX. For each of `NSRC` EX-stage source operands it produces a bypass select that picks the youngest matching producer. It also stalls ID when a load result will not be forwardable in time, counts stall cycles, and latches a sticky error on any unsafe forward.

## Interface
- `REG_AW`, 5, register address width; register 0 is hardwired zero and is never forwarded.
- `DEPTH`, 2, number of tracked stages past EX. Entry 0 is EX/MEM, entry `DEPTH-1` is the last bypassable stage.
- `NSRC`, 2, number of source operands checked per instruction.
- `LOAD_LAT`, 1, lowest entry index at which load data is forwardable. Legal range is 0 to `DEPTH-1`.
- `CNT_W`, 16, stall counter width.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `en`  in  1  pipeline advance; 0 freezes the history and the counters.
- `ex_valid`  in  1  EX slot holds a real instruction (0 for a bubble).
- `ex_regwrite`  in  1  EX instruction writes `ex_rd`.
- `ex_is_load`  in  1  EX instruction is a load.
- `ex_rd`  in  `REG_AW`  EX destination register.
- `ex_rs`  in  `NSRC*REG_AW`  EX sources, packed; operand i is at `[i*REG_AW +: REG_AW]`.
- `id_rs`  in  `NSRC*REG_AW`  ID sources, packed the same way.
- `id_rs_used`  in  `NSRC`  per-operand "ID actually reads this source".
- `fwd_sel`  out  `NSRC*SEL_W`  per-operand select, where `SEL_W = clog2(DEPTH+1)`. 0 = register file, k = entry k-1.
- `stall_id`  out  1  hold IF/ID and inject a bubble into EX.
- `stall_cnt`  out  `CNT_W`  saturating count of stall cycles.
- `fwd_err`  out  1  sticky unsafe-forward flag.

## Operation
- History register: `DEPTH` entries, each holding {`v`, `rd`, `ld`}.
- Shift rule: when `en`=1, entry 0 loads {`ex_valid & ex_regwrite & ex_rd!=0`, `ex_rd`, `ex_is_load`}, and entry j loads entry j-1. The oldest entry is discarded.
- Hold rule: when `en`=0, all entries hold.
- Forward select (combinational, per operand i):
  - Find the smallest j with `v[j]` and `rd[j]==ex_rs[i]`, with `ex_rs[i]!=0`.
  - `fwd_sel[i]` = j+1 if such a j exists, else 0. The youngest producer always wins.
- Load-use stall (combinational):
  - Candidate producers are EX itself at position p=0, then entry j at position p=j+1. Position is where the producer will sit when the ID instruction reaches EX.
  - For each operand with `id_rs_used[i]` and `id_rs[i]!=0`, take the youngest candidate writing `id_rs[i]`. The EX candidate counts only if `ex_valid & ex_regwrite`.
  - `stall_id` = 1 if any such youngest producer is a load with p < `LOAD_LAT`.
  - A younger non-load producer masks an older load.
- Stall count: on `en & stall_id`, `stall_cnt` increments and saturates at all-ones.
- Error flag: `fwd_err` is set when `en`=1 and any `fwd_sel[i]`=j+1 selects a load entry with j < `LOAD_LAT`. It clears only on reset.
- Register 0: never forwarded and never causes a stall.

## Timing
- Reset, asynchronous: all entries invalid, `stall_cnt`=0, `fwd_err`=0. While `rst_n`=0, `fwd_sel` and `stall_id` are forced to 0.
- Reset mid-stall drops all history immediately. The first post-reset cycle sees an empty history.
- Combinational paths: `fwd_sel` and `stall_id` are combinational from the current history plus the EX/ID inputs in the same cycle. There is no added latency.
- Registered state: history, `stall_cnt` and `fwd_err` update on the rising `clk` edge.
- Stall length: a load in EX with a dependent instruction in ID stalls for exactly `LOAD_LAT` cycles.
  - The pipeline drives `ex_valid`=0 for the bubbles.
  - The consumer then enters EX with `fwd_sel`=`LOAD_LAT`+1.
- Simultaneous `en`=0 and `stall_id`=1: outputs remain asserted, the counter does not advance, and the history holds.
- `LOAD_LAT`=0: `stall_id` is never asserted.

## Test plan
- Back-to-back dependency, default params: `add x5` in EX, next cycle EX `ex_rs[0]`=5 -> `fwd_sel[0]`=1, `stall_id`=0.
- Priority: writes to x7 one and two cycles before, EX `ex_rs[1]`=7 -> `fwd_sel[1]`=1. Same case with `ex_rd`=0 -> `fwd_sel`=0 on all operands.
- Load-use, defaults: `ld x3` in EX, ID `id_rs[0]`=3 used -> `stall_id`=1 for 1 cycle and `stall_cnt`=1. Next cycle consumer in EX -> `fwd_sel[0]`=2, `fwd_err`=0.
- `DEPTH`=3, `LOAD_LAT`=2: load then dependent -> `stall_id` high for exactly 2 cycles, `stall_cnt`=2, consumer `fwd_sel`=3. Forcing the consumer in early -> `fwd_err`=1 and it stays 1.
- Masking and freeze:
  - `ld x4` followed by `addi x4` and a dependent on x4 -> no stall, `fwd_sel`=1.
  - Holding `en`=0 for 3 cycles mid-sequence -> `fwd_sel` unchanged and `stall_cnt` unchanged.
- Reset mid-operation: deassert `rst_n` while `stall_id`=1 -> immediately `stall_id`=0, `fwd_sel`=0 and counter 0. After release with no new writes -> all selects remain 0.
